// File: rtl/bitwise_logic_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control,
// result status flags and a wrapping count of consumed results.
module bitwise_logic_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] count,
    input  logic             count_clr
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_NOR   = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ANDN  = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    function automatic logic [WIDTH-1:0] calc_op(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [2:0]       sel
    );
        logic [WIDTH-1:0] r;
        case (sel)
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_XOR:   r = x ^ y;
            OP_NAND:  r = ~(x & y);
            OP_NOR:   r = ~(x | y);
            OP_XNOR:  r = ~(x ^ y);
            OP_ANDN:  r = x & ~y;
            OP_PASSA: r = x;
            default:  r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    function automatic logic parity_f(input logic [WIDTH-1:0] x);
        return ^x;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             ones_r;
    logic             parity_r;
    logic [CNT_W-1:0] count_r;

    logic             s1_load_s;
    logic             s2_load_s;
    logic             in_ready_s;
    logic             out_fire_s;
    logic [WIDTH-1:0] result_s;

    // Handshake decode and stage-2 result from S1 contents
    always_comb begin
        s2_load_s  = s1_valid_r && (!out_valid_r || out_ready);
        in_ready_s = !s1_valid_r || s2_load_s;
        s1_load_s  = in_valid && in_ready_s;
        out_fire_s = out_valid_r && out_ready;
        result_s   = calc_op(s1_a_r, s1_b_r, s1_op_r);
    end

    // Stage 1 operand register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'b000;
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= a;
            s1_b_r     <= b;
            s1_op_r    <= op;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 result and flags; flags derive from the same value loaded into out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            ones_r      <= 1'b0;
            parity_r    <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            out_r       <= result_s;
            zero_r      <= (result_s == {WIDTH{1'b0}});
            ones_r      <= (result_s == {WIDTH{1'b1}});
            parity_r    <= parity_f(result_s);
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Consumed-result counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign zero      = zero_r;
    assign ones      = ones_r;
    assign parity    = parity_r;
    assign count     = count_r;

endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, pipelined bitwise logic unit generalising the fixed AND block: applies one of eight selectable bitwise operations to two WIDTH-bit operands and returns the result with status flags. It has a two-stage registered datapath, valid/ready flow control on both sides and a wrapping result counter. It sits between an operand source and a result consumer, either of which may stall.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 1..64
- CNT_W, 8, width of the completed-result counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select, sampled with the beat
- out_valid  out  1  result beat available
- out_ready  in  1  consumer accepts result beat
- out  out  WIDTH  result
- zero  out  1  result == 0
- ones  out  1  result == all ones
- parity  out  1  XOR-reduction of result
- count  out  CNT_W  number of result beats consumed, modulo 2^CNT_W
- count_clr  in  1  synchronous clear of count

## Operation
- op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (a & ~b), 111 PASS_A (a).
- Stage 1 (S1): on in_valid && in_ready, register a, b, op and set s1_valid.
- Stage 2 (S2): when S1 holds a beat and S2 can load, compute the op on S1 contents. Register out, zero, ones and parity, and set out_valid.
- Flags are computed from the registered-stage result and always match `out` on the same cycle.
- Load rules:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - s1_load = in_valid && in_ready
  - in_ready = !s1_valid || s2_load (combinational from out_ready through S2 state)
- A stage that is not loaded and not drained holds all contents unchanged. Outputs stay stable while out_valid && !out_ready.
- A stage whose content is drained with no new load clears its valid. Data registers may hold stale values.
- count increments by 1 on every out_valid && out_ready cycle and wraps from 2^CNT_W-1 to 0.
  - count_clr has priority over an increment in the same cycle; the result is count = 0.
- Reset (rst_n = 0 at a clock edge):
  - s1_valid = 0, out_valid = 0, out = 0, zero = 1, ones = 0, parity = 0, count = 0.
  - in_ready reads 1 on the first cycle after reset.
  - Reset mid-transfer discards all in-flight beats and nothing is emitted for them.
- Undefined op values do not exist: all 8 codes are legal.

## Timing
- Latency: a beat accepted at edge N appears on out with out_valid = 1 after edge N+1, provided S2 is free. That is 2 cycles from the in_valid sample to the output.
- Throughput: 1 beat/cycle with out_ready held high, and no bubbles.
- Backpressure: with out_ready = 0, at most two beats are buffered (S1 + S2). in_ready falls after the second acceptance.
- Recovery: when out_ready rises with both stages full, in_ready is 1 in that same cycle. The S1→S2 transfer and a new S1 load occur at the same edge.
- Simultaneous drain and load of S2 in one cycle is legal and loses no beat.
- There is no combinational path from in_valid or a/b/op to any output.

## Test plan
- Reset, then WIDTH=4, out_ready=1, one beat per op with a=1100, b=1010 → out, two cycles later: AND 1000, OR 1110, XOR 0110, NAND 0111, NOR 0001, XNOR 1001, ANDN 0100, PASS_A 1100.
- Flag check: AND with a=1100, b=0011 → out=0000, zero=1, ones=0, parity=0. OR with a=1111, b=0101 → out=1111, ones=1, zero=0, parity=0. PASS_A with a=0111 → parity=1.
- Backpressure: stream 4 beats with out_ready=0 → exactly 2 accepted, in_ready=0 from the 3rd cycle. Raise out_ready → all 4 results emitted in order, none lost or duplicated, count=4.
- Streaming: 16 back-to-back beats with out_ready=1 → 16 consecutive out_valid cycles starting 2 cycles after the first accept.
- Counter: CNT_W=2, consume 5 beats → count sequence 1,2,3,0,1. Assert count_clr on the same cycle as a consume → count=0.
- Reset mid-operation: both stages full, rst_n=0 for 1 cycle → out_valid=0, out=0000, zero=1, count=0, in_ready=1. No stale beat is emitted afterwards.
